xalu_muldiv: RTL

Multi-cycle multiply/divide unit (XALU) in the EX stage of the MIPS pipeline. It owns the HI/LO architectural registers. It executes mult/multu/div/divu/mthi/mtlo and drives the busy flag consumed by the stall control unit. The stall unit guarantees no MultFamily instruction issues while busy, so the XALU needs no back-pressure beyond busy.

---
 rtl/xalu_muldiv.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/xalu_muldiv.sv
// rtl/xalu_muldiv.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module xalu_muldiv #(
    parameter int MULT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // 32 restoring steps plus one sign-fixup cycle; fixed, not overridable.
    localparam int DIV_CYCLES = 33;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL     = 2'd1,
        S_DIV     = 2'd2,
        S_DIV_FIX = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] a_q;        // multiplicand, or dividend shifting into quotient
    logic [31:0] b_q;        // multiplier, or divisor magnitude
    logic [31:0] rem_q;      // partial remainder (always below the divisor)
    logic        mul_signed_q;
    logic        q_neg_q;
    logic        r_neg_q;

    logic        accept;
    logic        acc_mul;
    logic        acc_div;
    logic        busy_d;
    logic        done_d;
    logic        wr_mul;
    logic        wr_div;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] product;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        fits;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    assign accept  = start && !flush && (state_q == S_IDLE) &&
                     (op != 3'd0) && (op != 3'd7);
    assign acc_mul = accept && ((op == OP_MULT) || (op == OP_MULTU));
    assign acc_div = accept && ((op == OP_DIV) || (op == OP_DIVU));

    // Signed divide works on magnitudes; signs are reapplied in DIV_FIX.
    assign a_abs = ((op == OP_DIV) && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign b_abs = ((op == OP_DIV) && src_b[31]) ? (32'd0 - src_b) : src_b;

    // One 64x64 multiply of sign- or zero-extended operands gives both mult and multu.
    assign mul_a_ext = {{32{mul_signed_q & a_q[31]}}, a_q};
    assign mul_b_ext = {{32{mul_signed_q & b_q[31]}}, b_q};
    assign product   = mul_a_ext * mul_b_ext;

    // Restoring step: shift in next dividend bit, subtract divisor if it fits.
    assign rem_sh   = {rem_q, a_q[31]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign fits     = rem_sh[32] | ~rem_diff[32];
    assign rem_nx   = fits ? rem_diff[31:0] : rem_sh[31:0];
    assign quo_nx   = {a_q[30:0], fits};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (acc_mul) begin
                    state_d = S_MUL;
                end else if (acc_div) begin
                    state_d = S_DIV;
                end
            end
            S_MUL:     if (cnt_q == 5'd0) state_d = S_IDLE;
            S_DIV:     if (cnt_q == 5'd0) state_d = S_DIV_FIX;
            S_DIV_FIX: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Output decode: next busy/done and HI/LO result-write strobes.
    always_comb begin
        wr_mul = 1'b0;
        wr_div = 1'b0;
        busy_d = (state_d != S_IDLE);
        if (!flush) begin
            wr_mul = (state_q == S_MUL) && (cnt_q == 5'd0);
            wr_div = (state_q == S_DIV_FIX);
        end
        done_d = wr_mul | wr_div;
    end

    // Datapath, counter, HI/LO and registered busy/done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= 5'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rem_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (acc_mul) begin
                a_q          <= src_a;
                b_q          <= src_b;
                mul_signed_q <= (op == OP_MULT);
                cnt_q        <= 5'(MULT_CYCLES - 1);
            end else if (acc_div) begin
                a_q     <= a_abs;
                b_q     <= b_abs;
                rem_q   <= 32'd0;
                q_neg_q <= (op == OP_DIV) && (src_a[31] ^ src_b[31]);
                r_neg_q <= (op == OP_DIV) && src_a[31];
                cnt_q   <= 5'(DIV_CYCLES - 2);
            end else begin
                if ((state_q != S_IDLE) && (cnt_q != 5'd0)) begin
                    cnt_q <= cnt_q - 5'd1;
                end
                if (state_q == S_DIV) begin
                    rem_q <= rem_nx;
                    a_q   <= quo_nx;
                end
            end
            if (accept && (op == OP_MTHI)) begin
                hi <= src_a;
            end
            if (accept && (op == OP_MTLO)) begin
                lo <= src_a;
            end
            if (wr_mul) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end
            if (wr_div) begin
                lo <= q_neg_q ? (32'd0 - a_q) : a_q;
                hi <= r_neg_q ? (32'd0 - rem_q) : rem_q;
            end
        end
    end

endmodule
